cu_sequencer: RTL

- Multi-cycle control unit for the 32-bit RISC core.
- Consumes `Cu_opcode`/`Cu_imm` from DataPath and drives every `Cu_is*` control input of DataPath.
- Sequences fetch, decode, execute, memory and writeback with handshakes to instruction memory and data memory.
- Generates the PC and instruction-register enables.

---
 rtl/cu_sequencer_if.sv | 12 +
 rtl/cu_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cu_sequencer_if.sv
// rtl/cu_sequencer_if.sv - instruction/data memory handshake bundle for cu_sequencer
interface cu_sequencer_if;
  logic if_req;
  logic if_ack;
  logic ir_en;
  logic mem_req;
  logic mem_ack;
  logic pc_en;

  modport master (output if_req, ir_en, mem_req, pc_en, input if_ack, mem_ack);
  modport slave  (input if_req, ir_en, mem_req, pc_en, output if_ack, mem_ack);
endinterface

// File: rtl/cu_sequencer.sv
// rtl/cu_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control unit
module cu_sequencer #(
  parameter int MULDIV_LAT   = 4,
  parameter int MEM_WAIT_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4:0]     Cu_opcode,
  input  logic           Cu_imm,
  cu_sequencer_if.master bus,
  output logic Cu_isAdd, Cu_isSub, Cu_isCmp, Cu_isMul, Cu_isDiv, Cu_isMod, Cu_isLsl,
  output logic Cu_isLsr, Cu_isAsr, Cu_isOr, Cu_isAnd, Cu_isNot, Cu_isMov,
  output logic Cu_isLd, Cu_isSt, Cu_isBeq, Cu_isBgt, Cu_isUBranch, Cu_isCall, Cu_isRet,
  output logic Cu_isImmediate, Cu_isWb,
  output logic halted,
  output logic illegal_op,
  output logic mem_err
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t      state;
  logic [18:0] ctl, dec_ctl;
  logic        dec_wb, dec_md, dec_ld, dec_st, dec_hlt, dec_ill, dec_imm_ok;
  logic        wb_q, md_q, ld_q, st_q, hlt_q;
  logic [3:0]  md_cnt;
  logic [7:0]  mem_cnt;
  logic        if_req_q, mem_req_q, pc_en_q, is_wb_q, is_ld_q, is_st_q;

  // ctl bit order: add sub cmp mul div mod lsl lsr asr or and not mov beq bgt ub call ret imm
  always_comb begin
    dec_ctl    = '0;
    dec_wb     = 1'b0;
    dec_md     = 1'b0;
    dec_ld     = 1'b0;
    dec_st     = 1'b0;
    dec_hlt    = 1'b0;
    dec_ill    = 1'b0;
    dec_imm_ok = 1'b0;
    case (Cu_opcode)
      5'b00000: begin dec_ctl[0]  = 1'b1; dec_imm_ok = 1'b1; dec_wb = 1'b1; end
      5'b00001: begin dec_ctl[1]  = 1'b1; dec_imm_ok = 1'b1; dec_wb = 1'b1; end
      5'b00010: begin dec_ctl[3]  = 1'b1; dec_imm_ok = 1'b1; dec_wb = 1'b1; dec_md = 1'b1; end
      5'b00011: begin dec_ctl[4]  = 1'b1; dec_imm_ok = 1'b1; dec_wb = 1'b1; dec_md = 1'b1; end
      5'b00100: begin dec_ctl[5]  = 1'b1; dec_imm_ok = 1'b1; dec_wb = 1'b1; dec_md = 1'b1; end
      5'b00101: begin dec_ctl[2]  = 1'b1; dec_imm_ok = 1'b1; end
      5'b00110: begin dec_ctl[10] = 1'b1; dec_imm_ok = 1'b1; dec_wb = 1'b1; end
      5'b00111: begin dec_ctl[9]  = 1'b1; dec_imm_ok = 1'b1; dec_wb = 1'b1; end
      5'b01000: begin dec_ctl[11] = 1'b1; dec_imm_ok = 1'b1; dec_wb = 1'b1; end
      5'b01001: begin dec_ctl[12] = 1'b1; dec_imm_ok = 1'b1; dec_wb = 1'b1; end
      5'b01010: begin dec_ctl[6]  = 1'b1; dec_imm_ok = 1'b1; dec_wb = 1'b1; end
      5'b01011: begin dec_ctl[7]  = 1'b1; dec_imm_ok = 1'b1; dec_wb = 1'b1; end
      5'b01100: begin dec_ctl[8]  = 1'b1; dec_imm_ok = 1'b1; dec_wb = 1'b1; end
      5'b01101: ;
      5'b01110: begin dec_ctl[0]  = 1'b1; dec_imm_ok = 1'b1; dec_wb = 1'b1; dec_ld = 1'b1; end
      5'b01111: begin dec_ctl[0]  = 1'b1; dec_imm_ok = 1'b1; dec_st = 1'b1; end
      5'b10000: dec_ctl[13] = 1'b1;
      5'b10001: dec_ctl[14] = 1'b1;
      5'b10010: dec_ctl[15] = 1'b1;
      5'b10011: begin dec_ctl[15] = 1'b1; dec_ctl[16] = 1'b1; dec_wb = 1'b1; end
      5'b10100: begin dec_ctl[15] = 1'b1; dec_ctl[17] = 1'b1; end
      5'b11111: dec_hlt = 1'b1;
      default:  dec_ill = 1'b1;
    endcase
    dec_ctl[18] = dec_imm_ok & Cu_imm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      ctl        <= '0;
      wb_q       <= 1'b0;
      md_q       <= 1'b0;
      ld_q       <= 1'b0;
      st_q       <= 1'b0;
      hlt_q      <= 1'b0;
      md_cnt     <= '0;
      mem_cnt    <= '0;
      if_req_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      pc_en_q    <= 1'b0;
      is_wb_q    <= 1'b0;
      is_ld_q    <= 1'b0;
      is_st_q    <= 1'b0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      pc_en_q <= 1'b0;
      is_wb_q <= 1'b0;
      case (state)
        FETCH: begin
          if (if_req_q && bus.if_ack) begin
            if_req_q <= 1'b0;
            state    <= DECODE;
          end else begin
            if_req_q <= 1'b1;
          end
        end
        DECODE: begin
          ctl        <= dec_ctl;
          wb_q       <= dec_wb;
          md_q       <= dec_md;
          ld_q       <= dec_ld;
          st_q       <= dec_st;
          hlt_q      <= dec_hlt;
          illegal_op <= illegal_op | dec_ill;
          md_cnt     <= '0;
          state      <= EXEC;
        end
        EXEC: begin
          if (md_q && md_cnt != 4'(MULDIV_LAT - 1)) begin
            md_cnt <= md_cnt + 4'd1;
          end else if (ld_q || st_q) begin
            state     <= MEM;
            mem_req_q <= 1'b1;
            is_ld_q   <= ld_q;
            is_st_q   <= st_q;
            mem_cnt   <= '0;
          end else if (hlt_q) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state   <= WB;
            pc_en_q <= 1'b1;
            is_wb_q <= wb_q;
          end
        end
        MEM: begin
          // a timed-out access still retires through WB, but never writes back
          if (bus.mem_ack || mem_cnt == 8'(MEM_WAIT_MAX - 1)) begin
            state     <= WB;
            pc_en_q   <= 1'b1;
            is_wb_q   <= wb_q & bus.mem_ack;
            mem_err   <= mem_err | ~bus.mem_ack;
            mem_req_q <= 1'b0;
            is_ld_q   <= 1'b0;
            is_st_q   <= 1'b0;
          end else begin
            mem_cnt <= mem_cnt + 8'd1;
          end
        end
        WB: begin
          state    <= FETCH;
          if_req_q <= 1'b1;
          ctl      <= '0;
          wb_q     <= 1'b0;
          md_q     <= 1'b0;
          ld_q     <= 1'b0;
          st_q     <= 1'b0;
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.if_req  = if_req_q;
  assign bus.ir_en   = if_req_q & bus.if_ack;
  assign bus.mem_req = mem_req_q;
  assign bus.pc_en   = pc_en_q;
  assign Cu_isWb     = is_wb_q;
  assign Cu_isLd     = is_ld_q;
  assign Cu_isSt     = is_st_q;
  assign {Cu_isImmediate, Cu_isRet, Cu_isCall, Cu_isUBranch, Cu_isBgt, Cu_isBeq, Cu_isMov,
          Cu_isNot, Cu_isAnd, Cu_isOr, Cu_isAsr, Cu_isLsr, Cu_isLsl, Cu_isMod, Cu_isDiv,
          Cu_isMul, Cu_isCmp, Cu_isSub, Cu_isAdd} = ctl;
endmodule
